// File: rtl/uart_imem_loader.sv
// UART bootloader: receives A5 / N / 4*N data bytes (optional checksum) and writes 32-bit words to imem.
// Latency: outputs change one CLK after the stop-bit centre sample of each byte; imem_WE is a 1-cycle pulse.
// No backpressure: the UART line cannot be stalled; bytes are consumed as they arrive. Optional: LOADER_CHECKSUM_EN.
module uart_imem_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int MAX_WORDS    = 128,
    parameter int TIMEOUT_CLKS = 1_000_000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        rx,
    output logic        imem_WE,
    output logic [31:0] imem_A,
    output logic [31:0] imem_WD,
    output logic        core_hold,
    output logic        load_done,
    output logic        load_error
);
    localparam logic [15:0] CPB_M1  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [8:0]  MAXW    = 9'(MAX_WORDS);
    localparam logic [31:0] TMO     = 32'(TIMEOUT_CLKS);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {IDLE, COUNT, DATA,
`ifdef LOADER_CHECKSUM_EN
                              CHECK,
`endif
                              DONE, ERR} ld_state_t;

    logic        rx_meta, rx_s, rx_d;
    rx_state_t   rx_st, rx_nxt;
    logic [15:0] rx_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  rx_byte;
    logic        bit_tick, byte_valid, frame_err;

    ld_state_t   st, st_nxt;
    logic [7:0]  n_words, word_idx;
    logic [1:0]  byte_idx;
    logic [23:0] word_lo;
    logic [31:0] tmo_cnt;
    logic        in_frame, timeout, cnt_bad, last_byte;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    // Two-flop synchronizer plus one delay stage for falling-edge detection.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    // Receiver next-state: start check at half bit, data/stop sampled at bit centres.
    always_comb begin
        rx_nxt     = rx_st;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        bit_tick   = (rx_cnt == CPB_M1);
        case (rx_st)
            RX_IDLE:  if (rx_d && !rx_s) rx_nxt = RX_START;
            RX_START: if (rx_cnt == HALF_M1) rx_nxt = rx_s ? RX_IDLE : RX_BITS;
            RX_BITS:  if (bit_tick && bit_idx == 3'd7) rx_nxt = RX_STOP;
            RX_STOP: begin
                if (bit_tick) begin
                    rx_nxt     = RX_IDLE;
                    byte_valid = rx_s;
                    frame_err  = !rx_s;
                end
            end
            default:  rx_nxt = RX_IDLE;
        endcase
    end

    // Receiver state, bit-period counter and LSB-first shift register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_st   <= RX_IDLE;
            rx_cnt  <= '0;
            bit_idx <= '0;
            rx_byte <= '0;
        end else begin
            rx_st  <= rx_nxt;
            rx_cnt <= (rx_nxt != rx_st || bit_tick) ? 16'd0 : rx_cnt + 16'd1;
            if (rx_st == RX_START)
                bit_idx <= 3'd0;
            if (rx_st == RX_BITS && bit_tick) begin
                rx_byte <= {rx_s, rx_byte[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    // Loader next-state; a received byte takes priority over a coincident timeout.
    always_comb begin
        st_nxt    = st;
        in_frame  = (st == COUNT) || (st == DATA);
`ifdef LOADER_CHECKSUM_EN
        in_frame  = in_frame || (st == CHECK);
`endif
        timeout   = in_frame && (tmo_cnt == TMO);
        cnt_bad   = (rx_byte == 8'd0) || ({1'b0, rx_byte} > MAXW);
        last_byte = (byte_idx == 2'd3) && (word_idx == n_words - 8'd1);
        if (byte_valid) begin
            case (st)
                COUNT:   st_nxt = cnt_bad ? ERR : DATA;
`ifdef LOADER_CHECKSUM_EN
                DATA:    if (last_byte) st_nxt = CHECK;
                CHECK:   st_nxt = (rx_byte == csum) ? DONE : ERR;
`else
                DATA:    if (last_byte) st_nxt = DONE;
`endif
                default: if (rx_byte == 8'hA5) st_nxt = COUNT;
            endcase
        end else if (in_frame && (frame_err || timeout)) begin
            st_nxt = ERR;
        end
    end

    // Loader state register.
    always_ff @(posedge CLK) begin
        if (RST) st <= IDLE;
        else     st <= st_nxt;
    end

    // Word assembly, write strobe, index bookkeeping and inter-byte timeout counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            imem_WE  <= 1'b0;
            imem_A   <= '0;
            imem_WD  <= '0;
            n_words  <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            word_lo  <= '0;
            tmo_cnt  <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            imem_WE <= 1'b0;
            tmo_cnt <= (!in_frame || byte_valid) ? 32'd0 : tmo_cnt + 32'd1;
            if (st == COUNT && byte_valid && !cnt_bad) begin
                n_words  <= rx_byte;
                word_idx <= 8'd0;
                byte_idx <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
                csum     <= 8'd0;
`endif
            end
            if (st == DATA && byte_valid) begin
                byte_idx <= byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                csum     <= csum ^ rx_byte;
`endif
                case (byte_idx)
                    2'd0:    word_lo[7:0]   <= rx_byte;
                    2'd1:    word_lo[15:8]  <= rx_byte;
                    2'd2:    word_lo[23:16] <= rx_byte;
                    default: begin
                        imem_WE <= 1'b1;
                        imem_A  <= {22'd0, word_idx, 2'b00};
                        imem_WD <= {rx_byte, word_lo};
                        if (!last_byte) word_idx <= word_idx + 8'd1;
                    end
                endcase
            end
        end
    end

    assign core_hold  = (st != IDLE) && (st != DONE);
    assign load_done  = (st == DONE);
    assign load_error = (st == ERR);
endmodule

// File: tb/tb_uart_imem_loader.sv
// Self-checking bench for uart_imem_loader: directed protocol scenarios with randomized payloads.
// Latency: expectations checked after each byte/frame completes on the line.
// Backpressure: none; the bench drives the serial line at a fixed bit rate.
module tb_uart_imem_loader;
    localparam int CPB = 16;
    localparam int TMO = 2000;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        rx  = 1'b1;
    logic        imem_WE;
    logic [31:0] imem_A, imem_WD;
    logic        core_hold, load_done, load_error;

    int checks   = 0;
    int failures = 0;

    logic [31:0] wr_a[$];
    logic [31:0] wr_d[$];
    logic        prev_we   = 1'b0;
    int          long_we   = 0;
    logic [31:0] words [0:7];

    uart_imem_loader #(.CLKS_PER_BIT(CPB), .MAX_WORDS(128), .TIMEOUT_CLKS(TMO)) dut (
        .CLK(CLK), .RST(RST), .rx(rx),
        .imem_WE(imem_WE), .imem_A(imem_A), .imem_WD(imem_WD),
        .core_hold(core_hold), .load_done(load_done), .load_error(load_error)
    );

    always #5 CLK = ~CLK;

    // Write monitor: logs every strobe and flags any strobe longer than one cycle.
    always @(negedge CLK) begin
        if (imem_WE === 1'b1) begin
            wr_a.push_back(imem_A);
            wr_d.push_back(imem_WD);
            if (prev_we) long_we = long_we + 1;
        end
        prev_we = (imem_WE === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge CLK);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0; idle(CPB);
        for (int i = 0; i < 8; i++) begin rx = b[i]; idle(CPB); end
        rx = stop; idle(CPB);
        rx = 1'b1;
    endtask

    task automatic clear_log();
        wr_a.delete();
        wr_d.delete();
    endtask

    task automatic rand_words(input int n);
        for (int i = 0; i < n; i++) words[i] = $urandom;
    endtask

    // Model of a full frame: sync, count, little-endian words, optional XOR checksum (flip != 0 corrupts it).
    task automatic send_frame(input string tag, input int n, input logic [7:0] flip);
        logic [7:0] cs;
        logic [31:0] w;
        cs = 8'h00;
        send_byte(8'hA5, 1'b1);
        check({tag, "_hold_after_sync"}, {31'd0, core_hold}, 32'd1);
        send_byte(8'(n), 1'b1);
        for (int i = 0; i < n; i++) begin
            w = words[i];
            for (int k = 0; k < 4; k++) begin
                cs = cs ^ w[8*k +: 8];
                send_byte(w[8*k +: 8], 1'b1);
            end
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(cs ^ flip, 1'b1);
`endif
        idle(20);
    endtask

    task automatic check_writes(input string tag, input int nexp);
        check({tag, "_wr_count"}, wr_a.size(), nexp);
        for (int i = 0; i < nexp && i < wr_a.size(); i++) begin
            check({tag, "_wr_addr"}, wr_a[i], 32'(i * 4));
            check({tag, "_wr_data"}, wr_d[i], words[i]);
        end
        clear_log();
    endtask

    task automatic check_levels(input string tag, input logic h, input logic d, input logic e);
        check({tag, "_core_hold"},  {31'd0, core_hold},  {31'd0, h});
        check({tag, "_load_done"},  {31'd0, load_done},  {31'd0, d});
        check({tag, "_load_error"}, {31'd0, load_error}, {31'd0, e});
    endtask

    initial begin
        logic [7:0] g;
        int n;
        // Reset state.
        idle(5);
        check("rst_we", {31'd0, imem_WE}, 32'd0);
        check("rst_a", imem_A, 32'd0);
        check("rst_wd", imem_WD, 32'd0);
        check_levels("rst", 1'b0, 1'b0, 1'b0);
        RST = 1'b0;
        idle(10);
        check_levels("post_rst", 1'b0, 1'b0, 1'b0);

        // Directed valid load from known program words.
        words[0] = 32'h00100093;
        words[1] = 32'h00000013;
        send_frame("valid", 2, 8'h00);
        check_writes("valid", 2);
        check_levels("valid", 1'b0, 1'b1, 1'b0);

        // Randomized valid loads, back to back from DONE.
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, 3);
            rand_words(n);
            send_frame("rand", n, 8'h00);
            check_writes("rand", n);
            check_levels("rand", 1'b0, 1'b1, 1'b0);
        end

        // Bad counts: zero and MAX_WORDS+1.
        send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1); idle(20);
        check_writes("cnt0", 0);
        check_levels("cnt0", 1'b1, 1'b0, 1'b1);
        send_byte(8'hA5, 1'b1); send_byte(8'h81, 1'b1); idle(20);
        check_writes("cnt81", 0);
        check_levels("cnt81", 1'b1, 1'b0, 1'b1);

        // Framing error on the third data byte, then recovery.
        rand_words(1);
        send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1);
        check_levels("frm_mid", 1'b1, 1'b0, 1'b0);
        send_byte(words[0][7:0], 1'b1); send_byte(words[0][15:8], 1'b1);
        send_byte(words[0][23:16], 1'b0);
        idle(40);
        check_writes("frm", 0);
        check_levels("frm", 1'b1, 1'b0, 1'b1);
        rand_words(2);
        send_frame("frm_recover", 2, 8'h00);
        check_writes("frm_recover", 2);
        check_levels("frm_recover", 1'b0, 1'b1, 1'b0);

        // Inter-byte timeout: no error just below the limit, error just after.
        send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1);
        send_byte(8'h93, 1'b1); send_byte(8'h00, 1'b1);
        idle(TMO - 100);
        check_levels("tmo_before", 1'b1, 1'b0, 1'b0);
        idle(200);
        check_writes("tmo", 0);
        check_levels("tmo_after", 1'b1, 1'b0, 1'b1);

`ifdef LOADER_CHECKSUM_EN
        // Checksum mismatch: word is still written, load ends in error.
        rand_words(1);
        send_frame("csum_bad", 1, 8'h5A);
        check_writes("csum_bad", 1);
        check_levels("csum_bad", 1'b1, 1'b0, 1'b1);
`endif

        // Reset in the middle of the data phase.
        rand_words(1);
        send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1);
        send_byte(words[0][7:0], 1'b1); send_byte(words[0][15:8], 1'b1);
        check_levels("midrst_before", 1'b1, 1'b0, 1'b0);
        RST = 1'b1;
        @(negedge CLK);
        check_levels("midrst", 1'b0, 1'b0, 1'b0);
        check("midrst_a", imem_A, 32'd0);
        check("midrst_wd", imem_WD, 32'd0);
        RST = 1'b0;
        idle(10);
        for (int i = 0; i < 4; i++) begin
            g = 8'($urandom);
            if (g == 8'hA5) g = 8'h5A;
            send_byte(g, 1'b1);
        end
        idle(20);
        check_writes("garbage", 0);
        check_levels("garbage", 1'b0, 1'b0, 1'b0);

        check("we_single_cycle", long_we, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
